// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and the
// derivation of the shift-amount width from the register width.
package shift_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_RUN    = 2'd2,
      S_SETTLE = 2'd3
   } seq_state_e;

   localparam int DEF_WIDTH = 8;

   // One extra bit so that an amount equal to WIDTH is representable.
   function automatic int amt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/pace_counter.sv
// Reloadable down-counter with a terminal-count flag and a one-cycle lookahead
// of that flag, so that consumers can register pulses aligned with terminal count.
module pace_counter #(
   parameter int PACE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o,
   output logic tc_next_o
);

   localparam int CW = (PACE > 1) ? $clog2(PACE) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(PACE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Auto-reloads after reaching zero while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (en_i) begin
         cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o      = (cnt_q == '0);
   assign tc_next_o = (cnt_d == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Sequences load/shift controls for an external load/shift register: load a word,
// issue N paced right-shift pulses, then capture the register's output.
module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PACE  = 1,
   parameter int AMT_W = amt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AMT_W-1:0] amount,
   input  logic             asr_in,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] load_val,
   output logic             load_n,
   output logic             shift,
   output logic             asr,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   seq_state_e       state_q;
   seq_state_e       state_d;
   logic [AMT_W-1:0] rem_q;
   logic [AMT_W-1:0] amt_sat;
   logic             pace_load;
   logic             pace_en;
   logic             pace_tc;
   logic             pace_tc_next;

   assign amt_sat = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;

   pace_counter #(.PACE(PACE)) u_pace (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (pace_load),
      .en_i      (pace_en),
      .tc_o      (pace_tc),
      .tc_next_o (pace_tc_next)
   );

   always_comb begin
      state_d   = state_q;
      pace_load = 1'b0;
      pace_en   = 1'b0;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LOAD;
         S_LOAD: begin
            pace_load = 1'b1;
            state_d   = (rem_q != '0) ? S_RUN : S_SETTLE;
         end
         S_RUN: begin
            pace_en = 1'b1;
            if (pace_tc && rem_q == AMT_W'(1)) state_d = S_SETTLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from next state so each is a plain flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         load_val <= '0;
         load_n   <= 1'b1;
         shift    <= 1'b0;
         asr      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
      end else begin
         state_q <= state_d;
         load_n  <= (state_d != S_LOAD);
         shift   <= (state_d == S_RUN) && pace_tc_next;
         busy    <= (state_d != S_IDLE);
         done    <= (state_q == S_SETTLE);
         if (state_q == S_IDLE && start) begin
            load_val <= data_in;
            asr      <= asr_in;
            rem_q    <= amt_sat;
         end else if (state_q == S_RUN && pace_tc) begin
            rem_q <= rem_q - AMT_W'(1);
         end
         if (state_q == S_SETTLE) begin
            result <= q_in;
         end
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (PACE=1 and PACE=4), each driving a
// behavioural 8-bit load/shift register whose output feeds back into q_in.
module tb_shift_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start_s    [2];
   logic [7:0] data_s     [2];
   logic [3:0] amt_s      [2];
   logic       asr_in_s   [2];
   logic [7:0] q_s        [2];
   logic [7:0] load_val_s [2];
   logic       load_n_s   [2];
   logic       shift_s    [2];
   logic       asr_s      [2];
   logic       busy_s     [2];
   logic       done_s     [2];
   logic [7:0] result_s   [2];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_unit
         localparam int P = (gi == 0) ? 1 : 4;
         shift_sequencer #(.WIDTH(8), .PACE(P), .AMT_W(4)) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .start    (start_s[gi]),
            .data_in  (data_s[gi]),
            .amount   (amt_s[gi]),
            .asr_in   (asr_in_s[gi]),
            .q_in     (q_s[gi]),
            .load_val (load_val_s[gi]),
            .load_n   (load_n_s[gi]),
            .shift    (shift_s[gi]),
            .asr      (asr_s[gi]),
            .busy     (busy_s[gi]),
            .done     (done_s[gi]),
            .result   (result_s[gi])
         );
         // Downstream load/shift register (load has priority).
         always_ff @(posedge clk) begin
            if (!load_n_s[gi])
               q_s[gi] <= load_val_s[gi];
            else if (shift_s[gi])
               q_s[gi] <= {asr_s[gi] ? q_s[gi][7] : 1'b0, q_s[gi][7:1]};
         end
      end
   endgenerate

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] model_res(input logic [7:0] d, input int n, input logic s);
      logic signed [7:0] sd;
      sd = d;
      if (s) return 8'(sd >>> n);
      return d >> n;
   endfunction

   // Caller is positioned just after a negedge (inside cycle T).
   task automatic run_txn(input int u, input logic [7:0] d, input logic [3:0] a,
                          input logic s, input bit extra,
                          input logic [7:0] exp_res, input int exp_done);
      int pace;
      int n_exp;
      int shifts;
      int loads;
      int dones;
      pace   = (u == 0) ? 1 : 4;
      n_exp  = (exp_done - 3) / pace;
      shifts = 0;
      loads  = 0;
      dones  = 0;
      start_s[u]  = 1'b1;
      data_s[u]   = d;
      amt_s[u]    = a;
      asr_in_s[u] = s;
      @(negedge clk);
      start_s[u] = 1'b0;
      for (int j = 1; j <= exp_done + 2; j++) begin
         if (j == 1) begin
            chk("busy_at_load", int'(busy_s[u]), 1);
            chk("asr_held", int'(asr_s[u]), int'(s));
            chk("load_val_held", int'(load_val_s[u]), int'(d));
         end
         if (!load_n_s[u]) begin
            loads++;
            chk("load_cycle", j, 1);
            if (shift_s[u]) chk("load_and_shift", 1, 0);
         end
         if (shift_s[u]) begin
            shifts++;
            chk("shift_cycle", j, 1 + shifts * pace);
         end
         if (done_s[u]) begin
            dones++;
            chk("done_cycle", j, exp_done);
            chk("result", int'(result_s[u]), int'(exp_res));
            chk("busy_at_done", int'(busy_s[u]), 0);
         end
         start_s[u] = (extra && (j == 3 || j == 4)) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start_s[u] = 1'b0;
      chk("load_count", loads, 1);
      chk("shift_count", shifts, n_exp);
      chk("done_count", dones, 1);
      $display("txn unit=%0d data=%02h amt=%0d asr=%0d result=%02h expected=%02h",
               u, d, a, s, result_s[u], exp_res);
   endtask

   typedef struct {
      int         u;
      logic [7:0] d;
      logic [3:0] a;
      logic       s;
      bit         extra;
      logic [7:0] exp_res;
      int         exp_done;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{0, 8'hA5, 4'd1,  1'b0, 1'b0, 8'h52, 4};
      vecs[1] = '{0, 8'h96, 4'd3,  1'b1, 1'b0, 8'hF2, 6};
      vecs[2] = '{0, 8'h3C, 4'd0,  1'b0, 1'b0, 8'h3C, 3};
      vecs[3] = '{1, 8'h80, 4'd2,  1'b1, 1'b0, 8'hE0, 11};
      vecs[4] = '{0, 8'hFF, 4'd12, 1'b0, 1'b1, 8'h00, 11};

      reset_n = 1'b1;
      for (int u = 0; u < 2; u++) begin
         start_s[u] = 1'b0; data_s[u] = '0; amt_s[u] = '0; asr_in_s[u] = 1'b0;
      end
      #2 reset_n = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("rst_load_n", int'(load_n_s[u]), 1);
         chk("rst_shift", int'(shift_s[u]), 0);
         chk("rst_asr", int'(asr_s[u]), 0);
         chk("rst_busy", int'(busy_s[u]), 0);
         chk("rst_done", int'(done_s[u]), 0);
         chk("rst_result", int'(result_s[u]), 0);
         chk("rst_load_val", int'(load_val_s[u]), 0);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i].u, vecs[i].d, vecs[i].a, vecs[i].s, vecs[i].extra,
                 vecs[i].exp_res, vecs[i].exp_done);
      end

      // Abort mid-RUN: result must clear immediately and no done may follow.
      run_txn(0, 8'hA5, 4'd1, 1'b0, 1'b0, 8'h52, 4);
      start_s[0] = 1'b1; data_s[0] = 8'hC3; amt_s[0] = 4'd8; asr_in_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_in_run", int'(busy_s[0]), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy_s[0]), 0);
      chk("abort_result", int'(result_s[0]), 0);
      chk("abort_shift", int'(shift_s[0]), 0);
      chk("abort_load_n", int'(load_n_s[0]), 1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int j = 0; j < 12; j++) begin
         if (done_s[0] || busy_s[0]) chk("abort_quiet", 1, 0);
         @(negedge clk);
      end
      run_txn(0, 8'h3C, 4'd2, 1'b0, 1'b0, model_res(8'h3C, 2, 1'b0), 5);

      for (int i = 0; i < 24; i++) begin
         int         u;
         int         n;
         logic [7:0] d;
         logic [3:0] a;
         logic       s;
         u = int'($urandom_range(1, 0));
         d = 8'($urandom);
         a = 4'($urandom_range(15, 0));
         s = 1'($urandom);
         n = (a > 4'd8) ? 8 : int'(a);
         run_txn(u, d, a, s, 1'b0, model_res(d, n, s), 3 + n * ((u == 0) ? 1 : 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
